// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment display scanner.
package seven_seg_pkg;

  typedef enum logic [1:0] {IDLE, GUARD, SHOW} scan_state_t;

  localparam int              BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [6:0]      SEG_OFF = 7'b0;
  localparam logic [31:0]     AN_OFF  = {32{1'b1}};

  function automatic logic code_is_valid(input logic [BCD_W-1:0] code);
    return code <= BCD_MAX;
  endfunction

endpackage

// File: rtl/seven_seg_scan_controller_timer.sv
// Slot counter and digit index for the display scanner; strobes mark guard end,
// slot end, and (registered) the final cycle of each frame.
module seg_scan_timer #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int CNT_W        = $clog2(REFRESH_DIV),
  parameter int IDX_W        = $clog2(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  output logic [IDX_W-1:0] digit_idx,
  output logic             guard_end,
  output logic             slot_end,
  output logic             frame_end
);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] SLOT_PRE   = CNT_W'(REFRESH_DIV - 2);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] slot_cnt_reg;
  logic [IDX_W-1:0] digit_idx_reg;
  logic             frame_end_reg;

  // frame_end is raised one cycle early so it lines up with the last slot cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_reg  <= '0;
      digit_idx_reg <= '0;
      frame_end_reg <= 1'b0;
    end else if (clear) begin
      slot_cnt_reg  <= '0;
      digit_idx_reg <= '0;
      frame_end_reg <= 1'b0;
    end else begin
      frame_end_reg <= (slot_cnt_reg == SLOT_PRE) && (digit_idx_reg == IDX_LAST);
      if (slot_end) begin
        slot_cnt_reg  <= '0;
        digit_idx_reg <= (digit_idx_reg == IDX_LAST) ? '0 : digit_idx_reg + 1'b1;
      end else begin
        slot_cnt_reg <= slot_cnt_reg + 1'b1;
      end
    end
  end

  assign digit_idx = digit_idx_reg;
  assign guard_end = (slot_cnt_reg == GUARD_LAST);
  assign slot_end  = (slot_cnt_reg == SLOT_LAST);
  assign frame_end = frame_end_reg;

endmodule

// File: rtl/seven_seg_scan_controller.sv
// Time-multiplexes an external BCD-to-7-segment decoder across common-anode digits,
// with a double-buffered digit word, leading-zero blanking and a dark guard per slot.
module seven_seg_scan_controller
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        load,
  input  logic [BCD_W*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  input  logic                        blank_lz,
  output logic [BCD_W-1:0]            bcd_out,
  input  logic [6:0]                  segment7_in,
  output logic [6:0]                  seg_out,
  output logic                        dp_out,
  output logic [NUM_DIGITS-1:0]       an_out,
  output logic                        frame_done
);
  localparam int                    IDX_W   = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AN_DARK = AN_OFF[NUM_DIGITS-1:0];

  scan_state_t                 state_reg;
  logic [BCD_W*NUM_DIGITS-1:0] shadow_reg, active_reg;
  logic [NUM_DIGITS-1:0]       shadow_dp_reg, active_dp_reg;
  logic                        pending_reg;
  logic [NUM_DIGITS-1:0]       an_reg;
  logic [6:0]                  seg_reg;
  logic                        dp_reg;

  logic [IDX_W-1:0]      digit_idx;
  logic                  guard_end, slot_end, frame_end, timer_clear;
  logic [BCD_W-1:0]      digit_code [NUM_DIGITS];
  logic [NUM_DIGITS:1]   upper_zero;
  logic [NUM_DIGITS-1:0] lz_blanked, anode_sel;
  logic [BCD_W-1:0]      cur_code;
  logic                  cur_lit;

  assign timer_clear = (state_reg == IDLE) || !enable;

  seg_scan_timer #(
    .NUM_DIGITS   (NUM_DIGITS),
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (timer_clear),
    .digit_idx (digit_idx),
    .guard_end (guard_end),
    .slot_end  (slot_end),
    .frame_end (frame_end)
  );

  // upper_zero[i]: active digits i..NUM_DIGITS-1 are all zero
  assign upper_zero[NUM_DIGITS] = 1'b1;
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign digit_code[gi] = active_reg[BCD_W*gi +: BCD_W];
    assign anode_sel[gi]  = (digit_idx != IDX_W'(gi));
    if (gi == 0) begin : g_lsd
      assign lz_blanked[gi] = 1'b0;
    end else begin : g_upper
      assign upper_zero[gi] = (digit_code[gi] == '0) && upper_zero[gi+1];
      assign lz_blanked[gi] = blank_lz && upper_zero[gi];
    end
  end

  assign cur_code = digit_code[digit_idx];
  assign cur_lit  = code_is_valid(cur_code) && !lz_blanked[digit_idx];
  assign bcd_out  = (state_reg == IDLE) ? '0 : cur_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      an_reg    <= AN_DARK;
      seg_reg   <= SEG_OFF;
      dp_reg    <= 1'b0;
    end else begin
      an_reg  <= AN_DARK;
      seg_reg <= SEG_OFF;
      dp_reg  <= 1'b0;
      if (!enable) begin
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE:  state_reg <= GUARD;
          GUARD: begin
            if (guard_end) begin
              state_reg <= SHOW;
              an_reg    <= anode_sel;
              seg_reg   <= cur_lit ? segment7_in : SEG_OFF;
              dp_reg    <= active_dp_reg[digit_idx];
            end
          end
          SHOW: begin
            if (slot_end) begin
              state_reg <= GUARD;
            end else begin
              an_reg  <= anode_sel;
              seg_reg <= cur_lit ? segment7_in : SEG_OFF;
              dp_reg  <= active_dp_reg[digit_idx];
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // Active word only changes at the frame boundary, so a frame never tears
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_reg    <= '0;
      shadow_dp_reg <= '0;
      active_reg    <= '0;
      active_dp_reg <= '0;
      pending_reg   <= 1'b0;
    end else if (frame_end) begin
      if (load) begin
        active_reg    <= bcd_in;
        active_dp_reg <= dp_in;
      end else if (pending_reg) begin
        active_reg    <= shadow_reg;
        active_dp_reg <= shadow_dp_reg;
      end
      pending_reg <= 1'b0;
    end else if (load) begin
      shadow_reg    <= bcd_in;
      shadow_dp_reg <= dp_in;
      pending_reg   <= 1'b1;
    end
  end

  assign an_out     = an_reg;
  assign seg_out    = seg_reg;
  assign dp_out     = dp_reg;
  assign frame_done = frame_end;

endmodule
